// File: rtl/operand_fetch_stage_pkg.sv
// Shared types and constants for the operand fetch stage.
// Holds the state encoding, the operand-select enum and the load-use hazard test.
package operand_fetch_stage_pkg;

    localparam int unsigned DATA_W         = 32;
    localparam logic [3:0]  REG_PC         = 4'd15;
    localparam int unsigned PC_READ_OFFSET = 8;

    typedef enum logic {
        StEmpty,
        StFull
    } state_e;

    typedef enum logic [2:0] {
        SEL_PC,
        SEL_EX,
        SEL_WB,
        SEL_RF,
        SEL_IMM
    } op_sel_e;

    // R15 never hazards: it always reads PC+8, never a loaded value.
    function automatic logic haz_hit(
        input logic [3:0] r,
        input logic       haz_active,
        input logic [3:0] haz_rd,
        input logic       out_load_pending,
        input logic [3:0] out_rd
    );
        return (r != REG_PC) &&
               ((haz_active && (r == haz_rd)) || (out_load_pending && (r == out_rd)));
    endfunction

endpackage

// File: rtl/operand_fwd_mux.sv
// Combinational operand resolver: immediate, PC+8, EX/MEM, write-back, register file.
// Reports the chosen source for debug.
module operand_fwd_mux
    import operand_fetch_stage_pkg::*;
(
    input  logic [3:0]        i_rs,
    input  logic              i_use_imm,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_rf_data,
    input  logic              i_ex_valid,
    input  logic [3:0]        i_ex_rd,
    input  logic [DATA_W-1:0] i_ex_data,
    input  logic              i_wb_we,
    input  logic [3:0]        i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_data,
    output op_sel_e           o_sel
);

    always_comb begin
        o_data = i_rf_data;
        o_sel  = SEL_RF;
        if (i_use_imm) begin
            o_data = i_imm;
            o_sel  = SEL_IMM;
        end else if (i_rs == REG_PC) begin
            o_data = i_pc + DATA_W'(PC_READ_OFFSET);
            o_sel  = SEL_PC;
        end else if (i_ex_valid && (i_ex_rd == i_rs)) begin
            o_data = i_ex_data;
            o_sel  = SEL_EX;
        end else if (i_wb_we && (i_wb_rd == i_rs)) begin
            // Also covers read-during-write of the latch-based register file.
            o_data = i_wb_data;
            o_sel  = SEL_WB;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: resolves operands, registers them toward the ALU under
// a valid/ready handshake and interlocks load-use hazards with a countdown scoreboard.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [3:0]        i_in_rn,
    input  logic [3:0]        i_in_rm,
    input  logic [3:0]        i_in_rd,
    input  logic              i_in_rd_we,
    input  logic              i_in_is_load,
    input  logic              i_in_use_imm,
    input  logic [DATA_W-1:0] i_in_imm,
    input  logic [DATA_W-1:0] i_in_pc,
    output logic [3:0]        o_rf_a,
    output logic [3:0]        o_rf_b,
    input  logic [DATA_W-1:0] i_rf_pa,
    input  logic [DATA_W-1:0] i_rf_pb,
    input  logic              i_ex_fwd_valid,
    input  logic [3:0]        i_ex_fwd_rd,
    input  logic [DATA_W-1:0] i_ex_fwd_data,
    input  logic              i_wb_we,
    input  logic [3:0]        i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_op_a,
    output logic [DATA_W-1:0] o_out_op_b,
    output logic [3:0]        o_out_rd,
    output logic              o_out_rd_we,
    output logic              o_out_is_load,
    output op_sel_e           o_dbg_sel_a,
    output op_sel_e           o_dbg_sel_b
);

    localparam logic [1:0] LOAD_LAT_CNT = 2'(LOAD_LAT);

    state_e            r_state;
    logic [1:0]        r_haz_cnt;
    logic [3:0]        r_haz_rd;
    logic [DATA_W-1:0] r_op_a;
    logic [DATA_W-1:0] r_op_b;
    logic [3:0]        r_out_rd;
    logic              r_out_rd_we;
    logic              r_out_is_load;

    logic              w_full;
    logic              w_out_load;
    logic              w_hit_rn;
    logic              w_hit_rm;
    logic              w_stall;
    logic              w_accept;
    logic              w_drain;
    logic              w_load_leaving;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    assign o_rf_a = i_in_rn;
    assign o_rf_b = i_in_rm;

    assign w_full         = (r_state == StFull);
    assign w_out_load     = w_full && r_out_is_load && r_out_rd_we;
    assign w_hit_rn       = haz_hit(i_in_rn, r_haz_cnt != 2'd0, r_haz_rd, w_out_load, r_out_rd);
    assign w_hit_rm       = haz_hit(i_in_rm, r_haz_cnt != 2'd0, r_haz_rd, w_out_load, r_out_rd);
    assign w_stall        = i_in_valid && (w_hit_rn || (!i_in_use_imm && w_hit_rm));
    assign o_in_ready     = !i_flush && !w_stall && (!w_full || i_out_ready);
    assign w_accept       = i_in_valid && o_in_ready;
    assign w_drain        = w_full && i_out_ready && !w_accept;
    assign w_load_leaving = w_out_load && i_out_ready;

    operand_fwd_mux u_mux_a (
        .i_rs       (i_in_rn),
        .i_use_imm  (1'b0),
        .i_imm      ('0),
        .i_pc       (i_in_pc),
        .i_rf_data  (i_rf_pa),
        .i_ex_valid (i_ex_fwd_valid),
        .i_ex_rd    (i_ex_fwd_rd),
        .i_ex_data  (i_ex_fwd_data),
        .i_wb_we    (i_wb_we),
        .i_wb_rd    (i_wb_rd),
        .i_wb_data  (i_wb_data),
        .o_data     (w_op_a),
        .o_sel      (o_dbg_sel_a)
    );

    operand_fwd_mux u_mux_b (
        .i_rs       (i_in_rm),
        .i_use_imm  (i_in_use_imm),
        .i_imm      (i_in_imm),
        .i_pc       (i_in_pc),
        .i_rf_data  (i_rf_pb),
        .i_ex_valid (i_ex_fwd_valid),
        .i_ex_rd    (i_ex_fwd_rd),
        .i_ex_data  (i_ex_fwd_data),
        .i_wb_we    (i_wb_we),
        .i_wb_rd    (i_wb_rd),
        .i_wb_data  (i_wb_data),
        .o_data     (w_op_b),
        .o_sel      (o_dbg_sel_b)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StEmpty;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_out_rd      <= '0;
            r_out_rd_we   <= 1'b0;
            r_out_is_load <= 1'b0;
            r_haz_cnt     <= 2'd0;
            r_haz_rd      <= 4'd0;
        end else begin
            if (i_flush) begin
                r_state <= StEmpty;
            end else if (w_accept) begin
                r_state       <= StFull;
                r_op_a        <= w_op_a;
                r_op_b        <= w_op_b;
                r_out_rd      <= i_in_rd;
                r_out_rd_we   <= i_in_rd_we;
                r_out_is_load <= i_in_is_load;
            end else if (w_drain) begin
                r_state <= StEmpty;
            end

            // Flush does not clear this: a load that already left is downstream.
            if (w_load_leaving) begin
                r_haz_rd  <= r_out_rd;
                r_haz_cnt <= LOAD_LAT_CNT;
            end else if (r_haz_cnt != 2'd0) begin
                r_haz_cnt <= r_haz_cnt - 2'd1;
            end
        end
    end

    assign o_out_valid   = w_full;
    assign o_out_op_a    = r_op_a;
    assign o_out_op_b    = r_op_b;
    assign o_out_rd      = r_out_rd;
    assign o_out_rd_we   = r_out_rd_we;
    assign o_out_is_load = r_out_is_load;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: reset, operand resolution, forwarding,
// load-use interlock, backpressure, flush and reset during a stall.
module tb_operand_fetch_stage;
    import operand_fetch_stage_pkg::*;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_rn, in_rm, in_rd;
    logic              in_rd_we, in_is_load, in_use_imm;
    logic [DATA_W-1:0] in_imm, in_pc;
    logic [3:0]        rf_a, rf_b;
    logic [DATA_W-1:0] rf_pa, rf_pb;
    logic              ex_fwd_valid;
    logic [3:0]        ex_fwd_rd;
    logic [DATA_W-1:0] ex_fwd_data;
    logic              wb_we;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_op_a, out_op_b;
    logic [3:0]        out_rd;
    logic              out_rd_we, out_is_load;
    op_sel_e           sel_a, sel_b;

    int checks = 0;
    int errors = 0;

    operand_fetch_stage #(
        .LOAD_LAT (2)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_flush        (flush),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_rn        (in_rn),
        .i_in_rm        (in_rm),
        .i_in_rd        (in_rd),
        .i_in_rd_we     (in_rd_we),
        .i_in_is_load   (in_is_load),
        .i_in_use_imm   (in_use_imm),
        .i_in_imm       (in_imm),
        .i_in_pc        (in_pc),
        .o_rf_a         (rf_a),
        .o_rf_b         (rf_b),
        .i_rf_pa        (rf_pa),
        .i_rf_pb        (rf_pb),
        .i_ex_fwd_valid (ex_fwd_valid),
        .i_ex_fwd_rd    (ex_fwd_rd),
        .i_ex_fwd_data  (ex_fwd_data),
        .i_wb_we        (wb_we),
        .i_wb_rd        (wb_rd),
        .i_wb_data      (wb_data),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_op_a     (out_op_a),
        .o_out_op_b     (out_op_b),
        .o_out_rd       (out_rd),
        .o_out_rd_we    (out_rd_we),
        .o_out_is_load  (out_is_load),
        .o_dbg_sel_a    (sel_a),
        .o_dbg_sel_b    (sel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        flush = 0; in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0;
        in_rd_we = 0; in_is_load = 0; in_use_imm = 0; in_imm = 0; in_pc = 0;
        rf_pa = 0; rf_pb = 0; ex_fwd_valid = 0; ex_fwd_rd = 0; ex_fwd_data = 0;
        wb_we = 0; wb_rd = 0; wb_data = 0; out_ready = 1;
    endtask

    task automatic drive_instr(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                               input logic we, input logic ld);
        in_valid = 1; in_rn = rn; in_rm = rm; in_rd = rd;
        in_rd_we = we; in_is_load = ld; in_use_imm = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        in_rn = 4'd3; in_rm = 4'd4;
        #12;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if ({out_op_a, out_op_b} !== 64'h0) begin errors++; $display("FAIL reset_ops: got %h/%h want 0/0", out_op_a, out_op_b); end
        checks++; if ({out_rd, out_rd_we, out_is_load} !== 6'b0) begin errors++; $display("FAIL reset_ctrl: got %h %b %b want 0", out_rd, out_rd_we, out_is_load); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (rf_a !== 4'd3 || rf_b !== 4'd4) begin errors++; $display("FAIL rf_addr: got %0d/%0d want 3/4", rf_a, rf_b); end
        #10 rst_n = 1;
    endtask

    task automatic test_basic();
        drive_instr(4'd3, 4'd4, 4'd1, 1, 0);
        rf_pa = 32'h11; rf_pb = 32'h22;
        step();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        checks++; if (out_op_a !== 32'h11 || out_op_b !== 32'h22) begin errors++; $display("FAIL basic_ops: got %h/%h want 11/22", out_op_a, out_op_b); end
        checks++; if (out_rd !== 4'd1 || out_rd_we !== 1'b1) begin errors++; $display("FAIL basic_ctrl: got rd %0d we %b want 1/1", out_rd, out_rd_we); end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_pc_imm();
        drive_instr(4'd15, 4'd2, 4'd3, 1, 0);
        in_pc = 32'h100; in_use_imm = 1; in_imm = 32'h7;
        ex_fwd_valid = 1; ex_fwd_rd = 4'd15; ex_fwd_data = 32'hDEAD;
        rf_pa = 32'h55; rf_pb = 32'h66;
        #1;
        checks++; if (sel_a !== SEL_PC || sel_b !== SEL_IMM) begin errors++; $display("FAIL pc_imm_sel: got %0d/%0d want %0d/%0d", sel_a, sel_b, SEL_PC, SEL_IMM); end
        step();
        checks++; if (out_op_a !== 32'h108 || out_op_b !== 32'h7) begin errors++; $display("FAIL pc_imm_ops: got %h/%h want 108/7", out_op_a, out_op_b); end
        in_pc = 32'hFFFF_FFFC;
        step();
        checks++; if (out_op_a !== 32'h4) begin errors++; $display("FAIL pc_wrap: got %h want 4", out_op_a); end
        in_valid = 0; in_use_imm = 0; ex_fwd_valid = 0;
        step();
    endtask

    task automatic test_forwarding();
        drive_instr(4'd5, 4'd5, 4'd6, 1, 0);
        rf_pa = 32'h11; rf_pb = 32'h12;
        ex_fwd_valid = 1; ex_fwd_rd = 4'd5; ex_fwd_data = 32'hAA;
        wb_we = 1; wb_rd = 4'd5; wb_data = 32'hBB;
        step();
        checks++; if (out_op_a !== 32'hAA || out_op_b !== 32'hAA) begin errors++; $display("FAIL fwd_ex: got %h/%h want aa/aa", out_op_a, out_op_b); end
        ex_fwd_valid = 0;
        step();
        checks++; if (out_op_a !== 32'hBB || out_op_b !== 32'hBB) begin errors++; $display("FAIL fwd_wb: got %h/%h want bb/bb", out_op_a, out_op_b); end
        wb_we = 0;
        step();
        checks++; if (out_op_a !== 32'h11 || out_op_b !== 32'h12) begin errors++; $display("FAIL fwd_rf: got %h/%h want 11/12", out_op_a, out_op_b); end
        ex_fwd_valid = 1; ex_fwd_rd = 4'd4;
        wb_we = 1; wb_rd = 4'd5;
        #1;
        checks++; if (sel_a !== SEL_WB) begin errors++; $display("FAIL fwd_sel_wb: got %0d want %0d", sel_a, SEL_WB); end
        in_valid = 0; ex_fwd_valid = 0; wb_we = 0;
        step();
    endtask

    task automatic test_load_use();
        logic exp_ready;
        drive_instr(4'd1, 4'd1, 4'd2, 1, 1);
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b1 || out_is_load !== 1'b1) begin errors++; $display("FAIL load_accept: got v %b ld %b want 1/1", out_valid, out_is_load); end
        drive_instr(4'd2, 4'd3, 4'd4, 1, 0);
        rf_pa = 32'h1; rf_pb = 32'h33;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_ready = (i == 3);
            checks++;
            if (in_ready !== exp_ready) begin
                errors++;
                $display("FAIL load_use_ready[%0d]: got %b want %b", i, in_ready, exp_ready);
            end
            if (i < 3) step();
        end
        wb_we = 1; wb_rd = 4'd2; wb_data = 32'hC0DE;
        step();
        checks++; if (out_op_a !== 32'hC0DE || out_op_b !== 32'h33 || out_rd !== 4'd4) begin
            errors++; $display("FAIL load_use_data: got %h/%h rd %0d want c0de/33 rd 4", out_op_a, out_op_b, out_rd);
        end
        in_valid = 0; wb_we = 0;
        step();
    endtask

    task automatic test_back_to_back();
        drive_instr(4'd6, 4'd7, 4'd8, 1, 0);
        rf_pa = 32'h66; rf_pb = 32'h77;
        out_ready = 1;
        step();
        out_ready = 0;
        drive_instr(4'd9, 4'd10, 4'd11, 1, 0);
        rf_pa = 32'h99; rf_pb = 32'hAA;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op_a !== 32'h66 ||
                out_op_b !== 32'h77 || out_rd !== 4'd8) begin
                errors++;
                $display("FAIL hold[%0d]: got rdy %b v %b %h/%h rd %0d want 0 1 66/77 rd 8",
                         i, in_ready, out_valid, out_op_a, out_op_b, out_rd);
            end
            step();
        end
        out_ready = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b1 || out_op_a !== 32'h99 || out_op_b !== 32'hAA || out_rd !== 4'd11) begin
            errors++; $display("FAIL back_to_back: got v %b %h/%h rd %0d want 1 99/aa rd 11", out_valid, out_op_a, out_op_b, out_rd);
        end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 0;
        drive_instr(4'd1, 4'd1, 4'd6, 1, 1);
        rf_pa = 32'h10; rf_pb = 32'h10;
        step();
        drive_instr(4'd6, 4'd6, 4'd7, 1, 0);
        rf_pa = 32'h600; rf_pb = 32'h601;
        flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", out_valid); end
        flush = 0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_no_stall: got %b want 1", in_ready); end
        out_ready = 1;
        step();
        checks++; if (out_valid !== 1'b1 || out_op_a !== 32'h600 || out_op_b !== 32'h601 || out_rd !== 4'd7) begin
            errors++; $display("FAIL flush_consumer: got v %b %h/%h rd %0d want 1 600/601 rd 7", out_valid, out_op_a, out_op_b, out_rd);
        end
        in_valid = 0;
        step();
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1;
        drive_instr(4'd1, 4'd1, 4'd2, 1, 1);
        step();
        drive_instr(4'd2, 4'd3, 4'd5, 1, 0);
        rf_pa = 32'h222; rf_pb = 32'h333;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_pre_reset0: got %b want 0", in_ready); end
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_pre_reset1: got %b want 0", in_ready); end
        rst_n = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_clears_stall: got v %b rdy %b want 0/1", out_valid, in_ready); end
        rst_n = 1;
        step();
        checks++; if (out_valid !== 1'b1 || out_op_a !== 32'h222 || out_rd !== 4'd5) begin
            errors++; $display("FAIL post_reset_accept: got v %b %h rd %0d want 1 222 rd 5", out_valid, out_op_a, out_rd);
        end
        in_valid = 0;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pc_imm();
        test_forwarding();
        test_load_use();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
